// File: rtl/kfx86_mul_div_pkg.sv
// ----------------------------------------------------------------------------
// kfx86_mul_div_pkg
// Shared KFX86 accumulator header: the flags word seen by the accumulator ALU
// and the multiply/divide unit, and the multiply/divide opcode constants.
//
// Configuration macro used by the multiply/divide files:
//   KFX86_SIGNED_MULDIV_EN - enables IMUL/IDIV sign handling.
// ----------------------------------------------------------------------------
package kfx86_mul_div_pkg;

    // Arithmetic status flags, most significant field first.
    typedef struct packed {
        logic o;  // overflow
        logic s;  // sign
        logic z;  // zero
        logic a;  // auxiliary carry
        logic p;  // parity
        logic c;  // carry
    } flags_t;

    localparam logic [1:0] MULDIV_OP_MUL  = 2'b00;
    localparam logic [1:0] MULDIV_OP_IMUL = 2'b01;
    localparam logic [1:0] MULDIV_OP_DIV  = 2'b10;
    localparam logic [1:0] MULDIV_OP_IDIV = 2'b11;

    // Down-counter load value: the counter runs from this value to 0, giving
    // 8 (byte) or 16 (word) iterations.
    function automatic logic [3:0] last_iteration(input logic word);
        return word ? 4'd15 : 4'd7;
    endfunction

endpackage

// File: rtl/kfx86_muldiv_datapath.sv
// ----------------------------------------------------------------------------
// kfx86_muldiv_datapath
// Combinational single-iteration step of the multiply/divide unit, plus the
// two sign-negation units used for operand magnitudes and result fixup.
//
// Ports:
//   select_word      0 = byte (8-bit) iteration, 1 = word (16-bit)
//   is_div           0 = shift-add multiply step, 1 = restoring divide step
//   hi, lo           current partial remainder/product high half and
//                    quotient/multiplier low half (byte values in [7:0])
//   m                multiplicand or divisor magnitude
//   hi_next, lo_next halves after one iteration
//   neg_in_a/en_a/out_a  32-bit conditional negate (signed builds only)
//   neg_in_b/en_b/out_b  16-bit conditional negate (signed builds only)
//
// Configuration: KFX86_SIGNED_MULDIV_EN adds the negation ports.
// ----------------------------------------------------------------------------
module kfx86_muldiv_datapath
    import kfx86_mul_div_pkg::*;
(
    input  logic        select_word,
    input  logic        is_div,
    input  logic [15:0] hi,
    input  logic [15:0] lo,
    input  logic [15:0] m,
`ifdef KFX86_SIGNED_MULDIV_EN
    input  logic [31:0] neg_in_a,
    input  logic        neg_en_a,
    output logic [31:0] neg_out_a,
    input  logic [15:0] neg_in_b,
    input  logic        neg_en_b,
    output logic [15:0] neg_out_b,
`endif
    output logic [15:0] hi_next,
    output logic [15:0] lo_next
);

    logic [16:0] sum;
    logic [16:0] rem_shift;
    logic [16:0] diff;
    logic        q_bit;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        hi_next = hi;
        lo_next = lo;

        // Multiply: add the multiplicand when the current multiplier bit is
        // set, then shift {carry, hi, lo} right by one.
        sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : 17'd0);

        // Divide: shift the next dividend bit into the partial remainder and
        // keep the difference only if the divisor fits.
        rem_shift = select_word ? {hi, lo[15]} : {8'd0, hi[7:0], lo[7]};
        q_bit     = (rem_shift >= {1'b0, m});
        diff      = rem_shift - {1'b0, m};

        if (is_div) begin
            hi_next = q_bit ? diff[15:0] : rem_shift[15:0];
            lo_next = select_word ? {lo[14:0], q_bit} : {8'd0, lo[6:0], q_bit};
        end else begin
            hi_next = select_word ? sum[16:1] : {8'd0, sum[8:1]};
            lo_next = select_word ? {sum[0], lo[15:1]} : {8'd0, sum[0], lo[7:1]};
        end
    end

`ifdef KFX86_SIGNED_MULDIV_EN
    assign neg_out_a = neg_en_a ? (~neg_in_a + 32'd1) : neg_in_a;
    assign neg_out_b = neg_en_b ? (~neg_in_b + 16'd1) : neg_in_b;
`endif

endmodule

// File: rtl/kfx86_mul_div.sv
// ----------------------------------------------------------------------------
// kfx86_mul_div
// Multi-cycle MUL/IMUL/DIV/IDIV unit for the KFX86 execution stage. One bit is
// processed per cycle; the FSM is IDLE -> CHECK -> RUN -> FIX -> DONE.
//
// Ports:
//   clock, reset     clock; asynchronous active-high reset
//   start            request, sampled only in IDLE
//   opcode           00 MUL, 01 IMUL, 10 DIV, 11 IDIV
//   select_word      0 = byte, 1 = word operation
//   source_low/high  AX / DX (DX used only by word divides)
//   operand          multiplier or divisor (bytes use [7:0])
//   source_flags     incoming flags
//   busy             high from the cycle after start until done, inclusive
//   done             one-cycle completion pulse
//   divide_error     valid with done, requests INT 0
//   result_low/high  AX / DX results (high is 0 for byte operations)
//   out_flags        result flags
//
// Configuration: KFX86_SIGNED_MULDIV_EN enables IMUL/IDIV; without it
// opcode[0] is ignored and FIX is a one-cycle pass-through.
// ----------------------------------------------------------------------------
module kfx86_mul_div
    import kfx86_mul_div_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  opcode,
    input  logic        select_word,
    input  logic [15:0] source_low,
    input  logic [15:0] source_high,
    input  logic [15:0] operand,
    input  flags_t      source_flags,
    output logic        busy,
    output logic        done,
    output logic        divide_error,
    output logic [15:0] result_low,
    output logic [15:0] result_high,
    output flags_t      out_flags
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;

    // Latched request.
    logic        lat_div, lat_word;
    logic [15:0] lat_low, lat_high, lat_operand;
    flags_t      lat_flags;

    // Iteration registers.
    logic [15:0] hi_q, lo_q, m_q;
    logic [3:0]  count_q;
    logic [15:0] hi_next, lo_next;

    // CHECK-phase operand preparation.
    logic [31:0] a_raw, a_mask, a_mag;
    logic [15:0] b_raw, b_mag, wmask;
    logic [15:0] init_hi, init_lo, init_m;
    logic        div_zero, div_big, chk_error;

    // FIX-phase results.
    logic [31:0] product_raw, product;
    logic [15:0] quotient, remainder, err_high;
    logic [15:0] fix_low, fix_high;
    flags_t      fix_flags;
    logic        fix_error, mul_ov;

`ifdef KFX86_SIGNED_MULDIV_EN
    logic        lat_signed, neg_q, rem_neg_q, ovf_q;
    logic        a_sign, b_sign;
    logic [31:0] neg_in_a, neg_out_a;
    logic [15:0] neg_in_b, neg_out_b;
    logic        neg_en_a, neg_en_b;
`else
    logic        unused_opcode_lsb;
    assign unused_opcode_lsb = opcode[0];
`endif

    kfx86_muldiv_datapath u_datapath (
        .select_word (lat_word),
        .is_div      (lat_div),
        .hi          (hi_q),
        .lo          (lo_q),
        .m           (m_q),
`ifdef KFX86_SIGNED_MULDIV_EN
        .neg_in_a    (neg_in_a),
        .neg_en_a    (neg_en_a),
        .neg_out_a   (neg_out_a),
        .neg_in_b    (neg_in_b),
        .neg_en_b    (neg_en_b),
        .neg_out_b   (neg_out_b),
`endif
        .hi_next     (hi_next),
        .lo_next     (lo_next)
    );

    assign wmask       = lat_word ? 16'hFFFF : 16'h00FF;
    assign err_high    = lat_word ? lat_high : 16'h0000;
    assign product_raw = lat_word ? {hi_q, lo_q} : {16'd0, hi_q[7:0], lo_q[7:0]};

    // Raw operands: "a" is the multiplicand or dividend, "b" the multiplier
    // or divisor, zero-extended from their natural widths.
    always_comb begin
        a_raw  = lat_div ? (lat_word ? {lat_high, lat_low} : {16'd0, lat_low})
                         : (lat_word ? {16'd0, lat_low}    : {24'd0, lat_low[7:0]});
        a_mask = lat_div ? (lat_word ? 32'hFFFF_FFFF : 32'h0000_FFFF)
                         : (lat_word ? 32'h0000_FFFF : 32'h0000_00FF);
        b_raw  = lat_word ? lat_operand : {8'd0, lat_operand[7:0]};
    end

`ifdef KFX86_SIGNED_MULDIV_EN
    // The negation units convert operands to magnitudes in CHECK and restore
    // signs in FIX.
    always_comb begin
        a_sign   = lat_div ? (lat_word ? lat_high[15] : lat_low[15])
                           : (lat_word ? lat_low[15]  : lat_low[7]);
        b_sign   = lat_word ? lat_operand[15] : lat_operand[7];
        neg_in_a = a_raw;
        neg_en_a = lat_signed & a_sign;
        neg_in_b = b_raw;
        neg_en_b = lat_signed & b_sign;
        if (state_q == ST_FIX) begin
            neg_in_a = lat_div ? {16'd0, lo_q} : product_raw;
            neg_en_a = neg_q;
            neg_in_b = hi_q;
            neg_en_b = rem_neg_q;
        end
    end

    always_comb begin
        a_mag     = neg_out_a & a_mask;
        b_mag     = neg_out_b & wmask;
        product   = neg_out_a & (lat_word ? 32'hFFFF_FFFF : 32'h0000_FFFF);
        quotient  = neg_out_a[15:0] & wmask;
        remainder = neg_out_b & wmask;
    end
`else
    always_comb begin
        a_mag     = a_raw & a_mask;
        b_mag     = b_raw;
        product   = product_raw;
        quotient  = lo_q;
        remainder = hi_q;
    end
`endif

    // Initial iteration state and the early divide-error tests.
    always_comb begin
        init_hi   = lat_div ? (lat_word ? a_mag[31:16] : {8'd0, a_mag[15:8]}) : 16'd0;
        init_lo   = lat_div ? (lat_word ? a_mag[15:0]  : {8'd0, a_mag[7:0]})  : b_mag;
        init_m    = lat_div ? b_mag : a_mag[15:0];
        div_zero  = lat_div && (b_mag == 16'd0);
        // A high half at or above the divisor means the quotient cannot fit.
        div_big   = lat_div && (init_hi >= init_m);
`ifdef KFX86_SIGNED_MULDIV_EN
        // Signed overflow is reported from FIX so it completes at normal time.
        chk_error = div_zero || (div_big && !lat_signed);
`else
        chk_error = div_zero || div_big;
`endif
    end

    // Final results, flags and signed-overflow test.
    always_comb begin
        fix_error = 1'b0;
        fix_flags = lat_flags;
        mul_ov    = 1'b0;
        fix_low   = 16'd0;
        fix_high  = 16'd0;
        if (!lat_div) begin
            fix_low  = product[15:0];
            fix_high = lat_word ? product[31:16] : 16'd0;
            mul_ov   = lat_word ? (|product[31:16]) : (|product[15:8]);
`ifdef KFX86_SIGNED_MULDIV_EN
            if (lat_signed)
                mul_ov = lat_word ? (product[31:16] != {16{product[15]}})
                                  : (product[15:8]  != {8{product[7]}});
`endif
            fix_flags.c = mul_ov;
            fix_flags.o = mul_ov;
        end else begin
            fix_low  = lat_word ? quotient : {remainder[7:0], quotient[7:0]};
            fix_high = lat_word ? remainder : 16'd0;
`ifdef KFX86_SIGNED_MULDIV_EN
            // Quotient magnitude must fit a positive signed value.
            if (lat_signed && (ovf_q || (lat_word ? lo_q[15] : lo_q[7])))
                fix_error = 1'b1;
`endif
        end
        if (fix_error) begin
            fix_low   = lat_low;
            fix_high  = err_high;
            fix_flags = lat_flags;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: registers are written with non-blocking assignments so every
        // flop samples values from before the edge.
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_CHECK;
            ST_CHECK: state_d = chk_error ? ST_DONE : ST_RUN;
            ST_RUN:   if (count_q == 4'd0) state_d = ST_FIX;
            ST_FIX:   state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    // Datapath and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_div      <= 1'b0;
            lat_word     <= 1'b0;
            lat_low      <= 16'd0;
            lat_high     <= 16'd0;
            lat_operand  <= 16'd0;
            lat_flags    <= '0;
            hi_q         <= 16'd0;
            lo_q         <= 16'd0;
            m_q          <= 16'd0;
            count_q      <= 4'd0;
            divide_error <= 1'b0;
            result_low   <= 16'd0;
            result_high  <= 16'd0;
            out_flags    <= '0;
`ifdef KFX86_SIGNED_MULDIV_EN
            lat_signed   <= 1'b0;
            neg_q        <= 1'b0;
            rem_neg_q    <= 1'b0;
            ovf_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    lat_div     <= opcode[1];
                    lat_word    <= select_word;
                    lat_low     <= source_low;
                    lat_high    <= source_high;
                    lat_operand <= operand;
                    lat_flags   <= source_flags;
`ifdef KFX86_SIGNED_MULDIV_EN
                    lat_signed  <= opcode[0];
`endif
                end
                ST_CHECK: begin
                    hi_q    <= init_hi;
                    lo_q    <= init_lo;
                    m_q     <= init_m;
                    count_q <= last_iteration(lat_word);
`ifdef KFX86_SIGNED_MULDIV_EN
                    neg_q     <= lat_signed & (a_sign ^ b_sign);
                    rem_neg_q <= lat_signed & lat_div & a_sign;
                    ovf_q     <= lat_signed & div_big;
`endif
                    if (chk_error) begin
                        divide_error <= 1'b1;
                        result_low   <= lat_low;
                        result_high  <= err_high;
                        out_flags    <= lat_flags;
                    end
                end
                ST_RUN: begin
                    hi_q    <= hi_next;
                    lo_q    <= lo_next;
                    count_q <= count_q - 4'd1;
                end
                ST_FIX: begin
                    divide_error <= fix_error;
                    result_low   <= fix_low;
                    result_high  <= fix_high;
                    out_flags    <= fix_flags;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/kfx86_mul_div.md
# kfx86_mul_div

Multi-cycle multiply/divide unit for the KFX86 execution stage. It sits beside the single-cycle accumulator ALU and takes over the opcodes that ALU cannot finish in one cycle: MUL, IMUL, DIV and IDIV. Operands are taken at a start handshake and processed one bit per cycle. Results are returned in AX/DX-shaped halves together with updated flags and a divide-error indication.

## Interface
Parameters:
- None. Operand width is 8 or 16 bits, selected per operation by `select_word`.

Ports:
- `clock` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: request. Sampled only in IDLE.
- `opcode` in 2: 00 MUL, 01 IMUL, 10 DIV, 11 IDIV.
- `select_word` in 1: 0 = byte operation, 1 = word operation.
- `source_low` in 16: AX.
- `source_high` in 16: DX. Used only by word DIV/IDIV.
- `operand` in 16: multiplier or divisor. Byte operations use bits [7:0].
- `source_flags` in flags_t: incoming flags.
- `busy` out 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` out 1: one-cycle completion pulse.
- `divide_error` out 1: valid with `done`. Means the processor must raise INT 0.
- `result_low` out 16: AX result.
- `result_high` out 16: DX result. Word operations only; 0 for byte operations.
- `out_flags` out flags_t: result flags, valid from `done` onward.

## Operation
Data mapping:
- Byte MUL/IMUL: AL × operand[7:0] → AX in `result_low`.
- Word MUL/IMUL: AX × operand → DX:AX.
- Byte DIV/IDIV: AX ÷ operand[7:0] → AL = quotient, AH = remainder, both in `result_low`.
- Word DIV/IDIV: DX:AX ÷ operand → `result_low` = quotient, `result_high` = remainder.

State machine: IDLE → CHECK → RUN → FIX → DONE → IDLE.
- **IDLE**: `start` = 1 latches all inputs and moves to CHECK.
- **CHECK**: signed operations convert the operands to magnitudes.
  - DIV/IDIV with divisor = 0 → DONE with error.
  - Unsigned DIV whose high dividend half ≥ divisor → DONE with error.
  - Otherwise → RUN.
- **RUN**: N iterations, N = 8 (byte) or 16 (word), tracked by a down-counter.
  - Multiply: shift-add, one bit per iteration.
  - Divide: restoring division, one quotient bit per iteration.
- **FIX**: applies signs for signed operations.
  - Product is negated when the operand signs differ.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
  - IDIV whose quotient magnitude exceeds 7Fh (byte) or 7FFFh (word) → error.
- **DONE**: `done` = 1 for one cycle, then return to IDLE.

Flags:
- MUL: c = o = 1 when the upper half is nonzero.
- IMUL: c = o = 1 when the upper half is not the sign extension of the lower half.
- All other flags, and all flags for DIV/IDIV, pass through from `source_flags`.

Divide error:
- Results equal the latched `source_low`/`source_high`.
- Flags equal `source_flags`.

Output holding:
- Results and flags are registered and held after `done` until the next accepted `start`.
- `start` while busy is ignored; no queueing.

## Timing
Cycle numbering takes `start` sampled at edge 0.
- Normal completion: `done` is high between edges N+2 and N+3.
  - Byte: edges 10–11.
  - Word: edges 18–19.
- Error completion: `done` is high between edges 1 and 2. FIX-detected IDIV overflow is the exception: it completes at the normal time.
- A new `start` can be accepted at edge N+3, i.e. the first cycle back in IDLE.

Reset values (asynchronous reset, including mid-RUN): state = IDLE, and all of the following are 0:
- `busy`, `done`, `divide_error`
- `result_low`, `result_high`
- `out_flags`

## Configuration
Macro: `KFX86_SIGNED_MULDIV_EN`.
- **Defined**: IMUL and IDIV are supported as specified above.
- **Undefined**:
  - `opcode[0]` is ignored, so IMUL executes as MUL and IDIV as DIV.
  - The sign conversion, FIX negation and signed-overflow logic are not compiled.
  - FIX becomes a one-cycle pass-through, so timing is unchanged.

## Structure
- Reuse `flags_t` from the shared KFX86 accumulator header.
- Add the constants `MULDIV_OP_MUL`, `MULDIV_OP_IMUL`, `MULDIV_OP_DIV` and `MULDIV_OP_IDIV` to that same shared header.
- State encoding stays local to the block.
- One sub-module is natural: `kfx86_muldiv_datapath`. It holds the combinational single-iteration step (shift-add or trial subtract) and sign negation. The parent holds the FSM, counter and registers.

## Test plan
- **Byte MUL**: AL = 12h, operand = 10h → AX = 0120h, c = o = 1; `done` at edge 10.
- **Word MUL**: AX = FFFFh, operand = FFFFh → DX:AX = FFFE:0001h, c = o = 1; `done` at edge 18.
- **Word DIV**: DX:AX = 0001:0000h ÷ 0003h → AX = 5555h, DX = 0001h, `divide_error` = 0.
- **Byte DIV error cases**:
  - AX = 0100h ÷ 01h → `divide_error` = 1, `done` at edge 1, `result_low` = 0100h.
  - Divisor 00h → same response.
- **Signed cases** (with `KFX86_SIGNED_MULDIV_EN`):
  - IDIV byte AX = FFF9h ÷ 02h → AL = FDh, AH = FFh.
  - IMUL byte AL = FFh × FFh → AX = 0001h, c = o = 0.
- **Reset and re-start**:
  - `reset` pulsed mid-RUN → all outputs 0 and `busy` = 0 immediately.
  - `start` pulsed while busy → ignored; the result of the first operation is unchanged.
